// File: rtl/router_nic_port_pkg.sv
// Shared NoC constants for the router NIC port: packet width, VC-bit position
// and the two-VC numbering the NIC and router agree on.
package router_nic_port_pkg;

    localparam int NOC_DATA_W = 64;
    localparam int NOC_VC_BIT = NOC_DATA_W - 1;
    localparam int NIC_NUM_VC = 2;

    typedef enum logic {
        VC0 = 1'b0,
        VC1 = 1'b1
    } vc_e;

    // VC carried in the top bit of a packet of the given width.
    function automatic logic pkt_vc(input logic [NOC_DATA_W-1:0] pkt);
        return pkt[NOC_VC_BIT];
    endfunction

endpackage

// File: rtl/router_nic_port_if.sv
// Handshake bundle between the router NIC port and its two neighbours
// (NIC network channel and router switch). slave = port, master = environment.
interface router_nic_port_if
    import router_nic_port_pkg::*;
#(
    parameter int DATA_W = NOC_DATA_W
) ();

    logic              up_si;
    logic              up_ri;
    logic [DATA_W-1:0] up_di;
    logic              dn_so;
    logic              dn_ro;
    logic [DATA_W-1:0] dn_do;
    logic              sw_out_valid;
    logic              sw_out_ready;
    logic [DATA_W-1:0] sw_out_data;
    logic              sw_in_valid;
    logic              sw_in_ready;
    logic [DATA_W-1:0] sw_in_data;

    modport slave (
        input  up_si, up_di, dn_ro, sw_out_ready, sw_in_valid, sw_in_data,
        output up_ri, dn_so, dn_do, sw_out_valid, sw_out_data, sw_in_ready
    );

    modport master (
        output up_si, up_di, dn_ro, sw_out_ready, sw_in_valid, sw_in_data,
        input  up_ri, dn_so, dn_do, sw_out_valid, sw_out_data, sw_in_ready
    );

endinterface

// File: rtl/router_nic_port_vc_slot.sv
// vc_slot: one-entry packet register with a full flag. Data only moves on an
// accepted load; a full slot ignores further loads until cleared.
module router_nic_port_vc_slot
    import router_nic_port_pkg::*;
#(
    parameter int DATA_W = NOC_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clr,
    input  logic [DATA_W-1:0] d,
    output logic              full,
    output logic [DATA_W-1:0] q
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              load_ok;

    always_comb begin
        load_ok = load & ~full_q;
        full_d  = full_q;
        data_d  = data_q;
        if (load_ok) begin
            full_d = 1'b1;
            data_d = d;
        end else if (clr) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign q    = data_q;

endmodule

// File: rtl/router_nic_port.sv
// Router NIC port: alternating-VC bridge between a NIC network channel and the
// router switch, one slot per VC per direction, one-cycle crossing latency.
module router_nic_port
    import router_nic_port_pkg::*;
#(
    parameter int DATA_W = NOC_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    output logic                polarity,
    router_nic_port_if.slave    bus
);

    localparam int VC_BIT = DATA_W - 1;

    logic              polarity_q, polarity_d;
    logic              vc_err_q, vc_err_d;
    logic              ext_vc, int_vc;
    logic [1:0]        in_full, out_full;
    logic [1:0]        in_load, in_clr, out_load, out_clr;
    logic [DATA_W-1:0] in_slot  [2];
    logic [DATA_W-1:0] out_slot [2];

    // External side works on VC !polarity, internal on VC polarity, so the two
    // sides never touch the same slot in one cycle.
    always_comb begin
        polarity_d = ~polarity_q;
        ext_vc     = ~polarity_q;
        int_vc     = polarity_q;
        in_load    = '0;
        in_clr     = '0;
        out_load   = '0;
        out_clr    = '0;
        in_load[ext_vc]  = bus.up_si & ~in_full[ext_vc];
        in_clr[int_vc]   = in_full[int_vc] & bus.sw_out_ready;
        out_load[int_vc] = bus.sw_in_valid & ~out_full[int_vc];
        out_clr[ext_vc]  = out_full[ext_vc] & bus.dn_ro;
        vc_err_d = vc_err_q | (in_load[ext_vc] & (bus.up_di[VC_BIT] != ext_vc));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            polarity_q <= 1'b0;
            vc_err_q   <= 1'b0;
        end else begin
            polarity_q <= polarity_d;
            vc_err_q   <= vc_err_d;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_vc
        router_nic_port_vc_slot #(.DATA_W(DATA_W)) u_in (
            .clk   (clk),
            .reset (reset),
            .load  (in_load[k]),
            .clr   (in_clr[k]),
            .d     (bus.up_di),
            .full  (in_full[k]),
            .q     (in_slot[k])
        );
        router_nic_port_vc_slot #(.DATA_W(DATA_W)) u_out (
            .clk   (clk),
            .reset (reset),
            .load  (out_load[k]),
            .clr   (out_clr[k]),
            .d     (bus.sw_in_data),
            .full  (out_full[k]),
            .q     (out_slot[k])
        );
    end

    assign polarity         = polarity_q;
    assign bus.up_ri        = ~in_full[ext_vc];
    assign bus.sw_out_valid = in_full[int_vc];
    assign bus.sw_out_data  = in_slot[int_vc];
    assign bus.sw_in_ready  = ~out_full[int_vc];
    assign bus.dn_so        = out_full[ext_vc] & bus.dn_ro;
    assign bus.dn_do        = out_slot[ext_vc];

endmodule

// File: tb/tb_router_nic_port.sv
// Bench for router_nic_port: directed scenarios then random traffic, checked
// by a per-VC queue model of the port with a decoupled monitor.
module tb_router_nic_port;

    logic clk = 1'b0;
    logic reset;
    logic polarity;

    router_nic_port_if #(.DATA_W(64)) bus ();

    router_nic_port #(.DATA_W(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Expected packets per VC: toward switch and toward NIC. A non-empty queue
    // means that VC's buffer holds a packet (each VC holds at most one).
    logic [63:0] sw_exp0[$];
    logic [63:0] sw_exp1[$];
    logic [63:0] dn_exp0[$];
    logic [63:0] dn_exp1[$];
    logic [63:0] last_up [2];
    logic [63:0] last_dn [2];
    logic        vc_err_exp;
    logic        pol_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sw_size(input logic v);
        return v ? sw_exp1.size() : sw_exp0.size();
    endfunction

    function automatic int dn_size(input logic v);
        return v ? dn_exp1.size() : dn_exp0.size();
    endfunction

    // Scoreboard push: record what each completed input handshake must produce.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            sw_exp0.delete(); sw_exp1.delete();
            dn_exp0.delete(); dn_exp1.delete();
            last_up[0] = '0; last_up[1] = '0;
            last_dn[0] = '0; last_dn[1] = '0;
            vc_err_exp = 1'b0;
        end else begin
            if (bus.up_si && bus.up_ri) begin
                if (~polarity) sw_exp1.push_back(bus.up_di);
                else           sw_exp0.push_back(bus.up_di);
                last_up[~polarity] = bus.up_di;
                if (bus.up_di[63] != ~polarity) vc_err_exp = 1'b1;
            end
            if (bus.sw_in_valid && bus.sw_in_ready) begin
                if (polarity) dn_exp1.push_back(bus.sw_in_data);
                else          dn_exp0.push_back(bus.sw_in_data);
                last_dn[polarity] = bus.sw_in_data;
            end
        end
    end

    // Monitor: compare DUT outputs with the model and retire delivered packets.
    always @(negedge clk) begin
        logic        e, i;
        logic [63:0] head;
        if (reset) begin
            pol_exp = 1'b0;
        end else begin
            chk("polarity", {63'd0, polarity}, {63'd0, pol_exp});
            e = ~pol_exp;
            i = pol_exp;
            chk("up_ri", {63'd0, bus.up_ri}, {63'd0, sw_size(e) == 0});
            chk("sw_out_valid", {63'd0, bus.sw_out_valid}, {63'd0, sw_size(i) != 0});
            chk("sw_out_data", bus.sw_out_data, last_up[i]);
            if (bus.sw_out_valid && bus.sw_out_ready && sw_size(i) != 0) begin
                head = i ? sw_exp1.pop_front() : sw_exp0.pop_front();
                chk("sw_out_pkt", bus.sw_out_data, head);
            end
            chk("sw_in_ready", {63'd0, bus.sw_in_ready}, {63'd0, dn_size(i) == 0});
            chk("dn_so", {63'd0, bus.dn_so}, {63'd0, (dn_size(e) != 0) && bus.dn_ro});
            chk("dn_do", bus.dn_do, last_dn[e]);
            if (bus.dn_so && dn_size(e) != 0) begin
                head = e ? dn_exp1.pop_front() : dn_exp0.pop_front();
                chk("dn_pkt", bus.dn_do, head);
            end
            chk("vc_err", {63'd0, dut.vc_err_q}, {63'd0, vc_err_exp});
            pol_exp = ~pol_exp;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic align(input logic p);
        for (int k = 0; k < 3 && polarity !== p; k++) next_cycle();
    endtask

    task automatic nic_try(input logic [63:0] d, output logic acc);
        bus.up_si = 1'b1;
        bus.up_di = d;
        @(negedge clk);
        acc = bus.up_ri;
        next_cycle();
        bus.up_si = 1'b0;
    endtask

    task automatic nic_send(input logic [63:0] d);
        logic acc;
        logic vc;
        vc  = d[63];
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) begin
            align(~vc);
            nic_try(d, acc);
        end
    endtask

    task automatic sw_send(input logic [63:0] d, input logic vc);
        align(vc);
        bus.sw_in_valid = 1'b1;
        bus.sw_in_data  = d;
        next_cycle();
        bus.sw_in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        logic acc;
        reset            = 1'b1;
        bus.up_si        = 1'b0;
        bus.up_di        = '0;
        bus.dn_ro        = 1'b1;
        bus.sw_out_ready = 1'b1;
        bus.sw_in_valid  = 1'b0;
        bus.sw_in_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) next_cycle();

        // NIC -> switch on VC1, switch -> NIC on VC1
        align(1'b0);
        nic_try(64'h8000_0000_0000_00AA, acc);
        repeat (2) next_cycle();
        sw_send(64'h8000_0000_0000_0055, 1'b1);
        repeat (3) next_cycle();

        // backpressure: second VC1 packet must wait while the first is held
        bus.sw_out_ready = 1'b0;
        nic_send(64'h8000_0000_0000_00A1);
        for (int k = 0; k < 3; k++) begin
            align(1'b0);
            nic_try(64'h8000_0000_0000_00A2, acc);
        end
        bus.sw_out_ready = 1'b1;
        nic_send(64'h8000_0000_0000_00A2);
        repeat (3) next_cycle();

        // all four handshakes in one cycle
        align(1'b0);
        bus.up_si = 1'b1; bus.up_di = 64'h8000_0000_0000_00B1;
        bus.sw_in_valid = 1'b1; bus.sw_in_data = 64'h0000_0000_0000_00C0;
        next_cycle();
        bus.up_di = 64'h0000_0000_0000_00B0;
        bus.sw_in_data = 64'h8000_0000_0000_00C1;
        next_cycle();
        bus.up_si = 1'b0;
        bus.sw_in_valid = 1'b0;
        repeat (4) next_cycle();

        // wrong-VC packet: still delivered, flags vc_err until reset
        align(1'b0);
        nic_try(64'h0000_0000_0000_0BAD, acc);
        repeat (3) next_cycle();
        pulse_reset();
        repeat (2) next_cycle();

        for (int c = 0; c < 3000; c++) begin
            bus.up_si        = ($urandom_range(2) != 0);
            bus.up_di        = {$urandom, $urandom};
            if ($urandom_range(9) != 0) bus.up_di[63] = ~polarity;
            bus.sw_in_valid  = ($urandom_range(2) != 0);
            bus.sw_in_data   = {$urandom, $urandom};
            bus.sw_out_ready = ($urandom_range(3) != 0);
            bus.dn_ro        = ($urandom_range(3) != 0);
            if (c == 1500) reset = 1'b1;
            next_cycle();
            reset = 1'b0;
        end

        bus.up_si        = 1'b0;
        bus.sw_in_valid  = 1'b0;
        bus.sw_out_ready = 1'b1;
        bus.dn_ro        = 1'b1;
        repeat (6) next_cycle();
        chk("drain_left", 64'(sw_exp0.size() + sw_exp1.size() + dn_exp0.size() + dn_exp1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
